sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Synthesizable SDRAM device responder: the chip-side end of the command bus that `sdram_ctl` drives.
- Decodes CS/RAS/CAS/WE commands and enforces the power-up sequence: PRECHARGE ALL, two AUTO REFRESH, then MODE REGISTER SET.
- Tracks per-bank open rows, stores write data in a small internal array and returns read data after the programmed CAS latency.
- Used in simulation and on-FPGA loopback to validate the controller; flags protocol violations.

Parameters:
- DATA_W, 16, data bus width.
- ADDR_W, 13, SDRAM address bus width.
- ROW_KEEP, 2, low row-address bits kept in the storage index.
- COL_KEEP, 4, low column-address bits kept in the storage index.
- TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank.

Ports:
- clk, input, 1: clock; sampled on rising edge.
- rst, input, 1: asynchronous active-high reset.
- sd_cs_n, input, 1: chip select, active low.
- sd_ras_n, input, 1: row address strobe, active low.
- sd_cas_n, input, 1: column address strobe, active low.
- sd_we_n, input, 1: write enable, active low.
- sd_ba, input, 2: bank address.
- sd_addr, input, ADDR_W: row/column/mode address.
- sd_dqm, input, DATA_W/8: byte masks, active high.
- sd_dq_in, input, DATA_W: write data.
- sd_dq_out, output, DATA_W: read data.
- sd_dq_oe, output, 1: read data valid / drive enable.
- init_done, output, 1: init sequence complete.
- err, output, 1: sticky protocol error.
- err_code, output, 3: first error cause.

Behaviour:
- Reset (async, rst=1):
  - Outputs: sd_dq_out=0, sd_dq_oe=0, init_done=0, err=0, err_code=0.
  - State: init FSM=INIT_PRE, all banks IDLE, read pipeline cleared, mode CL=2.
  - Storage is not cleared.
  - Reset mid-read aborts pending data.
- Command decode (cs_n,ras_n,cas_n,we_n):
  - 1xxx or 0111 = NOP.
  - 0011 = ACTIVE.
  - 0101 = READ.
  - 0100 = WRITE.
  - 0010 = PRECHARGE; sd_addr[10]=1 means all banks.
  - 0001 = AUTO REFRESH.
  - 0000 = MODE REGISTER SET.
  - 0110 = BURST TERMINATE, treated as NOP.
- Init FSM:
  - INIT_PRE --PRECHARGE ALL--> INIT_REF1 --REFRESH--> INIT_REF2 --REFRESH--> INIT_MRS --MRS--> READY.
  - NOP holds the current state.
  - Any other command before READY: err_code=1; FSM holds.
- MRS:
  - sd_addr[6:4] sets CAS latency; only 2 and 3 are legal.
  - sd_addr[2:0] must be 0 (burst length 1).
  - Violation: err_code=2. CL is left unchanged.
  - MRS in READY with any bank ACTIVE: err_code=2.
  - init_done rises the cycle after a legal MRS in INIT_MRS.
- Banks:
  - Each bank keeps state IDLE/ACTIVE, the open row, and a 3-bit since-activate counter that saturates.
  - ACTIVE on an ACTIVE bank: err_code=3.
  - READ/WRITE on an IDLE bank: err_code=4.
  - READ/WRITE with counter < TRCD: err_code=5 (access still performed).
  - PRECHARGE of an IDLE bank is legal (no-op).
  - REFRESH with any bank ACTIVE: err_code=6.
- Storage:
  - Index = {ba, row[ROW_KEEP-1:0], col[COL_KEEP-1:0]}.
  - WRITE stores sd_dq_in in the same cycle as the command.
  - A byte whose sd_dqm bit is 1 is preserved.
- Read pipeline:
  - READ at edge N gives sd_dq_oe=1 and sd_dq_out=data for exactly one cycle, starting after edge N+CL.
  - Back-to-back READs give contiguous valid cycles.
  - A WRITE to the same address issued after the READ does not affect the already-fetched data.
  - sd_dqm applies to writes only.
- Errors: err is set on the first violation and never clears until reset. err_code latches the first cause only; later causes are ignored.

Test Plan:
- Reset, then PRE-ALL, REF, REF, MRS 0x020 (CL=2) -> init_done=1 one cycle after MRS, err=0.
- ACTIVE bank1 row 5; two NOPs; WRITE col 3 data 0xBEEF; READ col 3 -> sd_dq_oe=1 with 0xBEEF exactly 2 cycles after READ; same test with MRS 0x030 -> 3 cycles.
- WRITE 0x1234, then WRITE 0xABCD with dqm=2'b10 -> read returns 0x12CD.
- READ as the first command after reset -> err=1, err_code=1. A subsequent ACTIVE on an active bank leaves err_code=1.
- After init: READ on idle bank2 -> err_code=4. In a separate run, READ one cycle after ACTIVE (TRCD=2) -> err_code=5, data is still returned.
- Assert rst during the CL wait of a READ -> sd_dq_oe stays 0, init_done=0, FSM returns to INIT_PRE.

Source files
------------

// File: rtl/sdram_responder.sv
// SDRAM device-side responder: decodes the command bus, enforces the power-up
// sequence, tracks open rows, stores write data and returns reads after CAS latency.
module sdram_responder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned ROW_KEEP = 2,
  parameter int unsigned COL_KEEP = 4,
  parameter int unsigned TRCD     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sd_cs_n,
  input  logic                sd_ras_n,
  input  logic                sd_cas_n,
  input  logic                sd_we_n,
  input  logic [1:0]          sd_ba,
  input  logic [ADDR_W-1:0]   sd_addr,
  input  logic [DATA_W/8-1:0] sd_dqm,
  input  logic [DATA_W-1:0]   sd_dq_in,
  output logic [DATA_W-1:0]   sd_dq_out,
  output logic                sd_dq_oe,
  output logic                init_done,
  output logic                err,
  output logic [2:0]          err_code
);

  localparam int unsigned NBYTE = DATA_W / 8;
  localparam int unsigned IDX_W = 2 + ROW_KEEP + COL_KEEP;
  localparam int unsigned DEPTH = 1 << IDX_W;

  localparam logic [2:0] INIT_PRE  = 3'd0;
  localparam logic [2:0] INIT_REF1 = 3'd1;
  localparam logic [2:0] INIT_REF2 = 3'd2;
  localparam logic [2:0] INIT_MRS  = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;
  localparam logic [2:0] OP_REF = 3'd5;
  localparam logic [2:0] OP_MRS = 3'd6;

  localparam logic [2:0] ERR_INIT = 3'd1;
  localparam logic [2:0] ERR_MRS  = 3'd2;
  localparam logic [2:0] ERR_ACT  = 3'd3;
  localparam logic [2:0] ERR_IDLE = 3'd4;
  localparam logic [2:0] ERR_TRCD = 3'd5;
  localparam logic [2:0] ERR_REF  = 3'd6;

  logic [2:0]          state_q, state_d;
  logic                cl3_q, cl3_d;
  logic [3:0]          open_q, open_d;
  logic [ROW_KEEP-1:0] row_q [4];
  logic [ROW_KEEP-1:0] row_d [4];
  logic [2:0]          cnt_q [4];
  logic [2:0]          cnt_d [4];
  logic [2:0]          pv_q, pv_d;
  logic [DATA_W-1:0]   pd_q [3];
  logic [DATA_W-1:0]   pd_d [3];
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                init_done_q, init_done_d;
  logic                err_q, err_d;
  logic [2:0]          err_code_q, err_code_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [2:0]          op_c;
  logic [2:0]          cause_c;
  logic                rd_c, wr_c, mrs_ok_c;
  logic [IDX_W-1:0]    idx_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic                unused_addr_c;

  assign unused_addr_c = ^sd_addr;
  assign idx_c     = {sd_ba, row_q[sd_ba], sd_addr[COL_KEEP-1:0]};
  assign rd_data_c = mem_q[idx_c];
  assign mrs_ok_c  = ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) &&
                     (sd_addr[2:0] == 3'd0);

  // Command decode; deselect, NOP and burst terminate all map to OP_NOP.
  always_comb begin
    op_c = OP_NOP;
    if (!sd_cs_n) begin
      case ({sd_ras_n, sd_cas_n, sd_we_n})
        3'b011:  op_c = OP_ACT;
        3'b101:  op_c = OP_RD;
        3'b100:  op_c = OP_WR;
        3'b010:  op_c = OP_PRE;
        3'b001:  op_c = OP_REF;
        3'b000:  op_c = OP_MRS;
        default: op_c = OP_NOP;
      endcase
    end
  end

  // Init sequencing, bank tracking, error detection and read pipeline.
  always_comb begin
    state_d = state_q;
    cl3_d   = cl3_q;
    open_d  = open_q;
    cause_c = 3'd0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    for (int b = 0; b < 4; b++) begin
      row_d[b] = row_q[b];
      cnt_d[b] = (cnt_q[b] == 3'd7) ? 3'd7 : cnt_q[b] + 3'd1;
    end

    if (state_q != READY) begin
      if (op_c == OP_NOP) begin
        state_d = state_q;
      end else if (state_q == INIT_PRE && op_c == OP_PRE && sd_addr[10]) begin
        state_d = INIT_REF1;
      end else if (state_q == INIT_REF1 && op_c == OP_REF) begin
        state_d = INIT_REF2;
      end else if (state_q == INIT_REF2 && op_c == OP_REF) begin
        state_d = INIT_MRS;
      end else if (state_q == INIT_MRS && op_c == OP_MRS) begin
        if (mrs_ok_c) begin
          cl3_d   = sd_addr[4];
          state_d = READY;
        end else begin
          cause_c = ERR_MRS;
        end
      end else begin
        cause_c = ERR_INIT;
      end
    end else begin
      case (op_c)
        OP_ACT: begin
          if (open_q[sd_ba]) begin
            cause_c = ERR_ACT;
          end else begin
            open_d[sd_ba] = 1'b1;
            row_d[sd_ba]  = sd_addr[ROW_KEEP-1:0];
            cnt_d[sd_ba]  = 3'd1;
          end
        end
        OP_RD, OP_WR: begin
          if (!open_q[sd_ba]) begin
            cause_c = ERR_IDLE;
          end else begin
            // Early access is flagged but still carried out.
            if (cnt_q[sd_ba] < 3'(TRCD)) cause_c = ERR_TRCD;
            rd_c = (op_c == OP_RD);
            wr_c = (op_c == OP_WR);
          end
        end
        OP_PRE: begin
          if (sd_addr[10]) open_d = 4'b0000;
          else             open_d[sd_ba] = 1'b0;
        end
        OP_REF: begin
          if (|open_q) cause_c = ERR_REF;
        end
        OP_MRS: begin
          if ((|open_q) || !mrs_ok_c) cause_c = ERR_MRS;
          else                        cl3_d = sd_addr[4];
        end
        default: ;
      endcase
    end

    err_d       = err_q | (cause_c != 3'd0);
    err_code_d  = err_q ? err_code_q : cause_c;
    init_done_d = (state_d == READY);

    // Slot 2 reaches the pins after three edges, slot 1 after two.
    pv_d[2] = rd_c & cl3_q;
    pd_d[2] = (rd_c && cl3_q) ? rd_data_c : '0;
    if (rd_c && !cl3_q) begin
      pv_d[1] = 1'b1;
      pd_d[1] = rd_data_c;
    end else begin
      pv_d[1] = pv_q[2];
      pd_d[1] = pd_q[2];
    end
    pv_d[0]  = pv_q[1];
    pd_d[0]  = pd_q[1];
    dq_oe_d  = pv_q[0];
    dq_out_d = pd_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT_PRE;
      cl3_q       <= 1'b0;
      open_q      <= 4'b0000;
      pv_q        <= 3'b000;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      for (int b = 0; b < 4; b++) begin
        row_q[b] <= '0;
        cnt_q[b] <= 3'd0;
      end
      for (int s = 0; s < 3; s++) pd_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      cl3_q       <= cl3_d;
      open_q      <= open_d;
      pv_q        <= pv_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      for (int b = 0; b < 4; b++) begin
        row_q[b] <= row_d[b];
        cnt_q[b] <= cnt_d[b];
      end
      for (int s = 0; s < 3; s++) pd_q[s] <= pd_d[s];
    end
  end

  // Storage survives reset; masked bytes keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (!sd_dqm[b]) mem_q[idx_c][b*8 +: 8] <= sd_dq_in[b*8 +: 8];
      end
    end
  end

  assign sd_dq_out = dq_out_q;
  assign sd_dq_oe  = dq_oe_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed protocol scenarios plus a randomized
// legal-traffic phase, all checked against a behavioural device model.
module tb_sdram_responder;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_dq_in;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic        init_done;
  logic        err;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  sdram_responder dut (
    .clk(clk), .rst(rst),
    .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n),
    .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm), .sd_dq_in(sd_dq_in),
    .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe), .init_done(init_done),
    .err(err), .err_code(err_code)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } rd_t;
  rd_t rq[$];

  // Device model: init progress, CAS latency, bank bookkeeping, storage.
  int          m_stage;
  int          m_cl;
  bit          m_open[4];
  int          m_row[4];
  int          m_act[4];
  bit          m_err;
  int          m_code;
  logic [15:0] m_mem[256];
  bit          m_known[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stage = 0;
    m_cl    = 2;
    m_err   = 0;
    m_code  = 0;
    for (int b = 0; b < 4; b++) begin
      m_open[b] = 0;
      m_row[b]  = 0;
      m_act[b]  = 0;
    end
    rq.delete();
  endtask

  task automatic flag(input int code);
    if (!m_err) begin
      m_err  = 1;
      m_code = code;
    end
  endtask

  task automatic model_cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                           input logic [15:0] dq, input logic [1:0] dqm);
    int  b;
    int  idx;
    int  cl_req;
    bit  mrs_ok;
    rd_t r;
    b      = int'(ba);
    cl_req = int'(addr[6:4]);
    mrs_ok = (cl_req == 2 || cl_req == 3) && (addr[2:0] == 3'd0);
    if (c == C_NOP || c == 4'b0110 || c[3]) return;
    if (m_stage < 4) begin
      if (m_stage == 0 && c == C_PRE && addr[10]) m_stage = 1;
      else if ((m_stage == 1 || m_stage == 2) && c == C_REF) m_stage++;
      else if (m_stage == 3 && c == C_MRS) begin
        if (mrs_ok) begin
          m_cl    = cl_req;
          m_stage = 4;
        end else flag(2);
      end else flag(1);
      return;
    end
    case (c)
      C_ACT: begin
        if (m_open[b]) flag(3);
        else begin
          m_open[b] = 1;
          m_row[b]  = int'(addr) % 4;
          m_act[b]  = cyc;
        end
      end
      C_RD, C_WR: begin
        if (!m_open[b]) flag(4);
        else begin
          if (cyc - m_act[b] < 2) flag(5);
          idx = b * 64 + m_row[b] * 16 + int'(addr) % 16;
          if (c == C_RD) begin
            r.due   = cyc + m_cl;
            r.data  = m_mem[idx];
            r.known = m_known[idx];
            rq.push_back(r);
          end else begin
            if (!dqm[0]) m_mem[idx][7:0]  = dq[7:0];
            if (!dqm[1]) m_mem[idx][15:8] = dq[15:8];
            if (dqm == 2'b00) m_known[idx] = 1;
          end
        end
      end
      C_PRE: begin
        if (addr[10]) for (int k = 0; k < 4; k++) m_open[k] = 0;
        else m_open[b] = 0;
      end
      C_REF: if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) flag(6);
      C_MRS: begin
        if (m_open[0] || m_open[1] || m_open[2] || m_open[3] || !mrs_ok) flag(2);
        else m_cl = cl_req;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    bit          exp_v;
    bit          exp_k;
    logic [15:0] exp_d;
    rd_t         r;
    exp_v = 0;
    exp_k = 0;
    exp_d = 16'h0000;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r     = rq.pop_front();
      exp_v = 1;
      exp_k = r.known;
      exp_d = r.data;
    end
    chk("dq_oe", 32'(sd_dq_oe), 32'(exp_v));
    if (exp_v && exp_k) chk("dq_data", 32'(sd_dq_out), 32'(exp_d));
    else if (!exp_v)    chk("dq_idle", 32'(sd_dq_out), 32'h0);
    chk("init_done", 32'(init_done), 32'(m_stage == 4));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [15:0] dq, input logic [1:0] dqm);
    {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = c;
    sd_ba    = ba;
    sd_addr  = addr;
    sd_dq_in = dq;
    sd_dqm   = dqm;
  endtask

  // Present one command for one edge, update the model, check at the falling edge.
  task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [15:0] dq, input logic [1:0] dqm);
    drive(c, ba, addr, dq, dqm);
    @(posedge clk);
    cyc++;
    model_cmd(c, ba, addr, dq, dqm);
    @(negedge clk);
    drive(C_NOP, 2'd0, 13'd0, 16'd0, 2'd0);
    check_outputs();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0, 16'd0, 2'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(C_NOP, 2'd0, 13'd0, 16'd0, 2'd0);
    #1;
    chk("rst_oe", 32'(sd_dq_oe), 32'h0);
    chk("rst_dq", 32'(sd_dq_out), 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_code", 32'(err_code), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic init_seq(input logic [12:0] mode);
    issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'd0);
    issue(C_REF, 2'd0, 13'd0, 16'd0, 2'd0);
    issue(C_REF, 2'd0, 13'd0, 16'd0, 2'd0);
    issue(C_MRS, 2'd0, mode, 16'd0, 2'd0);
  endtask

  initial begin
    logic [12:0] a;
    int          b;
    int          r;
    for (int i = 0; i < 256; i++) m_known[i] = 0;
    rst = 1'b1;
    drive(C_NOP, 2'd0, 13'd0, 16'd0, 2'd0);
    model_reset();
    do_reset();

    // Power-up with CL=2, then write/read bank1 row5 col3.
    init_seq(13'h020);
    chk("init_done_after_mrs", 32'(init_done), 32'h1);
    issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'd0);
    nop(2);
    issue(C_WR, 2'd1, 13'd3, 16'hBEEF, 2'b00);
    issue(C_RD, 2'd1, 13'd3, 16'd0, 2'd0);
    nop(1);
    chk("cl2_not_yet", 32'(sd_dq_oe), 32'h0);
    nop(1);
    chk("cl2_valid", 32'(sd_dq_oe), 32'h1);
    chk("cl2_data", 32'(sd_dq_out), 32'hBEEF);
    nop(1);
    chk("cl2_one_cycle", 32'(sd_dq_oe), 32'h0);

    // Switch to CL=3 and repeat the read.
    issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'd0);
    issue(C_MRS, 2'd0, 13'h030, 16'd0, 2'd0);
    issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'd0);
    nop(2);
    issue(C_RD, 2'd1, 13'd3, 16'd0, 2'd0);
    nop(2);
    chk("cl3_not_yet", 32'(sd_dq_oe), 32'h0);
    nop(1);
    chk("cl3_data", 32'(sd_dq_out), 32'hBEEF);

    // Byte mask, then a write that must not disturb an already-issued read.
    issue(C_WR, 2'd1, 13'd3, 16'h1234, 2'b00);
    issue(C_WR, 2'd1, 13'd3, 16'hABCD, 2'b10);
    issue(C_RD, 2'd1, 13'd3, 16'd0, 2'd0);
    issue(C_WR, 2'd1, 13'd3, 16'h5555, 2'b00);
    nop(2);
    chk("dqm_merge", 32'(sd_dq_out), 32'h12CD);
    issue(C_RD, 2'd1, 13'd3, 16'd0, 2'd0);
    issue(C_RD, 2'd1, 13'd3, 16'd0, 2'd0);
    nop(4);

    // Back to CL=2 and random legal traffic.
    issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'd0);
    issue(C_MRS, 2'd0, 13'h020, 16'd0, 2'd0);
    for (int i = 0; i < 400; i++) begin
      b = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (!m_open[b]) begin
        a = 13'($urandom) & 13'h1FFD;
        issue(C_ACT, 2'(b), a, 16'd0, 2'd0);
      end else if (cyc + 1 - m_act[b] < 2) begin
        nop(1);
      end else if (r == 0) begin
        issue(C_PRE, 2'(b), 13'd0, 16'd0, 2'd0);
      end else if (r <= 4) begin
        a = 13'($urandom_range(0, 3));
        issue(C_WR, 2'(b), a, 16'($urandom),
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
      end else begin
        a = 13'($urandom_range(0, 3));
        issue(C_RD, 2'(b), a, 16'd0, 2'd0);
      end
    end
    nop(4);
    chk("random_no_err", 32'(err), 32'h0);

    // Command before init; later violations must not replace the first cause.
    do_reset();
    issue(C_RD, 2'd0, 13'd0, 16'd0, 2'd0);
    chk("early_read_code", 32'(err_code), 32'h1);
    init_seq(13'h020);
    issue(C_ACT, 2'd0, 13'd0, 16'd0, 2'd0);
    issue(C_ACT, 2'd0, 13'd0, 16'd0, 2'd0);
    chk("first_cause_kept", 32'(err_code), 32'h1);

    // Read on an idle bank.
    do_reset();
    init_seq(13'h020);
    issue(C_RD, 2'd2, 13'd0, 16'd0, 2'd0);
    chk("idle_bank_code", 32'(err_code), 32'h4);

    // Read inside tRCD: flagged, data still returned.
    do_reset();
    init_seq(13'h020);
    issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'd0);
    issue(C_RD, 2'd1, 13'd3, 16'd0, 2'd0);
    chk("trcd_code", 32'(err_code), 32'h5);
    nop(2);
    chk("trcd_data_valid", 32'(sd_dq_oe), 32'h1);

    // Reset during the CAS wait cancels the pending read.
    do_reset();
    init_seq(13'h020);
    issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'd0);
    nop(2);
    issue(C_RD, 2'd1, 13'd3, 16'd0, 2'd0);
    do_reset();
    nop(3);
    chk("midread_no_oe", 32'(sd_dq_oe), 32'h0);
    issue(C_REF, 2'd0, 13'd0, 16'd0, 2'd0);
    chk("back_to_init_pre", 32'(err_code), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
